// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of fifo_stream_reader.
// master is the reader's view; slave is the FIFO/downstream view.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_pop, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_pop, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a registered-read FIFO into a 3-entry skid buffer and streams words out on valid/ready.
// fifo_pop is derived from registered occupancy only, so m_ready never reaches it combinationally.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 busy
);

  logic [1:0]            occ;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [2:0]            pending;
  logic                  capture;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] head;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words buffered plus the one on its way; never let this exceed the 3 slots.
  assign pending      = {1'b0, occ} + {2'b00, inflight};
  assign bus.fifo_pop = en && !bus.fifo_empty && (pending < 3'd3);

  assign capture     = inflight;
  assign bus.m_valid = (occ != 2'd0);
  assign transfer    = bus.m_valid && bus.m_ready;
  assign busy        = (occ != 2'd0) || inflight;

  always_comb begin
    head = buf_q[0];
    case (rd_ptr)
      2'd1:    head = buf_q[1];
      2'd2:    head = buf_q[2];
      default: head = buf_q[0];
    endcase
  end

  assign bus.m_data = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      occ      <= 2'd0;
      rd_count <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      inflight <= bus.fifo_pop;

      if (capture) begin
        for (int i = 0; i < 3; i++) begin
          if (wr_ptr == 2'(i)) begin
            buf_q[i] <= bus.fifo_data;
          end
        end
        wr_ptr <= ptr_inc(wr_ptr);
      end

      if (transfer) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        rd_count <= rd_count + CNT_WIDTH'(1);
      end

      case ({capture, transfer})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a FIFO model feeds the DUT, a monitor checks every beat.
// A second instance with a 4-bit counter exercises rd_count wrap.
module tb_fifo_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        en_w;
  logic        m_ready;
  logic [15:0] rd_count;
  logic        busy;
  logic [3:0]  rd_count_w;
  logic        busy_w;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();
  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus_w ();

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus), .rd_count(rd_count), .busy(busy)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en_w), .bus(bus_w), .rd_count(rd_count_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  // FIFO model with one-cycle registered read
  logic [7:0] mem [256];
  logic [7:0] wr_idx = 8'd0;
  logic [7:0] rd_idx = 8'd0;
  logic [7:0] fifo_q = 8'd0;

  assign bus.fifo_empty = (wr_idx == rd_idx);
  assign bus.fifo_data  = fifo_q;
  assign bus.m_ready    = m_ready;

  always @(posedge clk) begin
    if (bus.fifo_pop) begin
      fifo_q <= mem[rd_idx];
      rd_idx <= rd_idx + 8'd1;
    end
  end

  int words_w = 0;
  int pops_w  = 0;
  int beats_w = 0;
  assign bus_w.fifo_empty = (pops_w == words_w);
  assign bus_w.fifo_data  = 8'hA5;
  assign bus_w.m_ready    = 1'b1;

  always @(posedge clk) begin
    if (bus_w.fifo_pop) pops_w <= pops_w + 1;
  end

  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int beat_cnt = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_idx] = d;
    wr_idx = wr_idx + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || !bus.fifo_empty) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  // Monitor: samples after the stimulus settles, ahead of the next rising edge
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (hold_prev) begin
        check("hold_valid", 32'(bus.m_valid), 32'd1);
        check("hold_data", 32'(bus.m_data), 32'(hold_data));
      end
      if (bus.fifo_pop) begin
        pop_cnt++;
        check("pop_while_empty", 32'(bus.fifo_empty), 32'd0);
      end
      if (bus.m_valid && bus.m_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", bus.m_data);
        end else begin
          check("beat_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
      end
      hold_prev = bus.m_valid && !bus.m_ready;
      hold_data = bus.m_data;
      if (bus_w.m_valid) begin
        beats_w++;
        check("wrap_beat_data", 32'(bus_w.m_data), 32'hA5);
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    int lat;
    int bubbles;
    int viol;
    int p0;
    int b0;

    rst_n = 1'b0; en = 1'b0; en_w = 1'b0; m_ready = 1'b0;
    #12;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_fifo_pop", 32'(bus.fifo_pop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_rd_count_w", 32'(rd_count_w), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full stream of 16 words
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    b0 = beat_cnt;
    @(negedge clk); en = 1'b1; #1;
    check("fs_first_pop", 32'(bus.fifo_pop), 32'd1);
    check("fs_valid_early", 32'(bus.m_valid), 32'd0);
    lat = 0;
    while (!bus.m_valid && lat < 10) begin
      step();
      lat++;
    end
    check("fs_latency", 32'(lat), 32'd2);
    bubbles = 0;
    for (int i = 0; i < 16; i++) begin
      if (!(bus.m_valid && bus.m_ready)) bubbles++;
      step();
    end
    check("fs_bubbles", 32'(bubbles), 32'd0);
    wait_idle("fs_idle");
    check("fs_rd_count", 32'(rd_count), 32'd16);
    check("fs_beats", 32'(beat_cnt - b0), 32'd16);

    // Reset mid-stream with two words buffered and one in flight
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
    repeat (3) @(negedge clk);
    check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
    rst_n = 1'b0;
    wr_idx = rd_idx;
    exp_q.delete();
    #1;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_fifo_pop", 32'(bus.fifo_pop), 32'd0);
    check("mid_rst_rd_count", 32'(rd_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    check("post_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("post_rst_fifo_pop", 32'(bus.fifo_pop), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rd_count", 32'(rd_count), 32'd0);

    // Backpressure
    @(negedge clk);
    en = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    @(negedge clk);
    en = 1'b1;
    p0 = pop_cnt; b0 = beat_cnt;
    repeat (8) step();
    check("bp_pops", 32'(pop_cnt - p0), 32'd3);
    check("bp_pop_low", 32'(bus.fifo_pop), 32'd0);
    check("bp_valid", 32'(bus.m_valid), 32'd1);
    check("bp_head", 32'(bus.m_data), 32'h00);
    @(negedge clk); m_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_beats", 32'(beat_cnt - b0), 32'd8);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Disable right after a pop
    @(negedge clk);
    en = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'h20 + 8'(i));
    b0 = beat_cnt;
    @(negedge clk); en = 1'b1; #1;
    check("dis_pop_before", 32'(bus.fifo_pop), 32'd1);
    @(negedge clk); en = 1'b0;
    p0 = beat_cnt;
    viol = 0;
    repeat (4) begin
      #1;
      if (bus.fifo_pop) viol++;
      @(negedge clk);
    end
    check("dis_no_pop", 32'(viol), 32'd0);
    check("dis_inflight_beats", 32'(beat_cnt - p0), 32'd1);
    en = 1'b1;
    wait_idle("dis_idle");
    check("dis_beats", 32'(beat_cnt - b0), 32'd8);
    check("dis_sb_empty", 32'(exp_q.size()), 32'd0);

    // Single word with m_ready toggling
    @(negedge clk);
    en = 1'b0; m_ready = 1'b0;
    push_word(8'h55);
    @(negedge clk);
    en = 1'b1;
    p0 = pop_cnt; b0 = beat_cnt;
    repeat (10) begin
      @(negedge clk);
      m_ready = !m_ready;
    end
    #1;
    check("eb_pops", 32'(pop_cnt - p0), 32'd1);
    check("eb_beats", 32'(beat_cnt - b0), 32'd1);
    check("eb_busy", 32'(busy), 32'd0);

    // Counter wrap on the 4-bit instance
    @(negedge clk);
    words_w = 17; en_w = 1'b1;
    repeat (40) step();
    check("wrap_pops", 32'(pops_w), 32'd17);
    check("wrap_beats", 32'(beats_w), 32'd17);
    check("wrap_rd_count", 32'(rd_count_w), 32'd1);
    check("wrap_busy", 32'(busy_w), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
